// File: rtl/fc_sched_pkg.sv
// rtl/fc_sched_pkg.sv - shared states, thresholds and Q4.12 constants for fc_scheduler
package fc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam logic [15:0] TH_HI_DEF = 16'h0A00;
    localparam logic [15:0] TH_LO_DEF = 16'h0600;

    localparam int          FRAC_BITS = 12;
    localparam logic [15:0] ONE       = 16'h1000;

endpackage

// File: rtl/fc_scheduler_rr_arbiter.sv
// rtl/fc_scheduler_rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] idx,
    output logic            valid
);

    logic [CH_W-1:0] sel;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        sel   = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel = CH_W'((int'(ptr) + i) % N_CH);
            if (!valid && req[sel]) begin
                valid      = 1'b1;
                grant[sel] = 1'b1;
                idx        = sel;
            end
        end
    end

endmodule

// File: rtl/fc_scheduler.sv
// rtl/fc_scheduler.sv - round-robin scheduler sharing one FC/sigmoid engine across channels
module fc_scheduler
    import fc_sched_pkg::*;
#(
    parameter int                    N_CH       = 4,
    parameter int                    INPUT_SIZE = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] TH_HI      = TH_HI_DEF,
    parameter logic [DATA_WIDTH-1:0] TH_LO      = TH_LO_DEF,
    parameter int                    TIMEOUT    = 64,
    localparam int                   CH_W       = $clog2(N_CH),
    localparam int                   VEC_W      = INPUT_SIZE * DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         ch_req,
    input  logic [N_CH*VEC_W-1:0]   ch_h,
    output logic [N_CH-1:0]         ch_ack,
    output logic [VEC_W-1:0]        fc_h,
    output logic                    fc_valid,
    input  logic [DATA_WIDTH-1:0]   fc_prob,
    input  logic                    fc_done,
    output logic                    res_valid,
    output logic [CH_W-1:0]         res_ch,
    output logic [DATA_WIDTH-1:0]   res_prob,
    output logic                    res_jammed,
    output logic                    res_timeout,
    output logic                    switch_req,
    output logic [CH_W-1:0]         switch_ch,
    output logic [N_CH-1:0]         jam_status
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t                  state, state_nxt;
    logic [CH_W-1:0]         rr_ptr;
    logic [CH_W-1:0]         cur_ch;
    logic [WD_W-1:0]         wd_cnt;
    logic [N_CH-1:0]         arb_grant;
    logic [CH_W-1:0]         arb_idx;
    logic                    arb_valid;
    logic                    wd_end;
    logic [DATA_WIDTH-1:0]   prob_nxt;
    logic                    jam_cur;
    logic                    jam_nxt;

    rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .req   (ch_req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Ack is a Mealy output of IDLE; gating with rst_n keeps it low while reset is held.
    assign ch_ack = (state == IDLE && rst_n) ? arb_grant : '0;

    always_comb begin
        state_nxt = state;
        wd_end    = (wd_cnt == WD_W'(TIMEOUT - 1));
        prob_nxt  = fc_done ? fc_prob : '0;
        jam_cur   = jam_status[cur_ch];
        jam_nxt   = jam_cur;
        if (fc_done) begin
            if (fc_prob > TH_HI) begin
                jam_nxt = 1'b1;
            end else if (fc_prob < TH_LO) begin
                jam_nxt = 1'b0;
            end
        end
        case (state)
            IDLE:    if (arb_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (fc_done || wd_end) state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            cur_ch      <= '0;
            wd_cnt      <= '0;
            fc_h        <= '0;
            fc_valid    <= 1'b0;
            res_valid   <= 1'b0;
            res_ch      <= '0;
            res_prob    <= '0;
            res_jammed  <= 1'b0;
            res_timeout <= 1'b0;
            switch_req  <= 1'b0;
            switch_ch   <= '0;
            jam_status  <= '0;
        end else begin
            fc_valid   <= 1'b0;
            res_valid  <= 1'b0;
            switch_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        fc_h     <= ch_h[int'(arb_idx)*VEC_W +: VEC_W];
                        cur_ch   <= arb_idx;
                        fc_valid <= 1'b1;
                    end
                end
                ISSUE: wd_cnt <= '0;
                WAIT: begin
                    // Result registers load on the way into REPORT so they line up with res_valid.
                    if (fc_done || wd_end) begin
                        res_valid          <= 1'b1;
                        res_ch             <= cur_ch;
                        res_prob           <= prob_nxt;
                        res_timeout        <= !fc_done;
                        res_jammed         <= jam_nxt;
                        jam_status[cur_ch] <= jam_nxt;
                        if (!jam_cur && jam_nxt) begin
                            switch_req <= 1'b1;
                            switch_ch  <= cur_ch;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                REPORT: rr_ptr <= (cur_ch == CH_W'(N_CH - 1)) ? '0 : cur_ch + CH_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_scheduler.sv
// tb/tb_fc_scheduler.sv - scoreboard bench for fc_scheduler
module tb_fc_scheduler;

    localparam int          N_CH    = 4;
    localparam int          VEC_W   = 256;
    localparam int          TIMEOUT = 64;
    localparam logic [15:0] TH_HI   = 16'h0A00;
    localparam logic [15:0] TH_LO   = 16'h0600;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] prob;
        logic        jammed;
        logic        tmo;
        logic        sw;
        logic [1:0]  sw_ch;
        logic [3:0]  jam;
    } res_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N_CH-1:0]       ch_req = '0;
    logic [N_CH*VEC_W-1:0] ch_h = '0;
    logic [N_CH-1:0]       ch_ack;
    logic [VEC_W-1:0]      fc_h;
    logic                  fc_valid;
    logic [15:0]           fc_prob = '0;
    logic                  fc_done = 1'b0;
    logic                  res_valid;
    logic [1:0]            res_ch;
    logic [15:0]           res_prob;
    logic                  res_jammed;
    logic                  res_timeout;
    logic                  switch_req;
    logic [1:0]            switch_ch;
    logic [N_CH-1:0]       jam_status;

    res_t         act_res;
    logic [288:0] all_out;
    assign act_res = {res_ch, res_prob, res_jammed, res_timeout, switch_req, switch_ch, jam_status};
    assign all_out = {ch_ack, fc_h, fc_valid, res_valid, res_ch, res_prob, res_jammed,
                      res_timeout, switch_req, switch_ch, jam_status};

    res_t       exp_q[$];
    logic [3:0] jam_m = '0;
    logic [1:0] sw_ch_m = '0;
    int         vectors = 0;
    int         miscompares = 0;
    int         stray_acks = 0;
    int         stray_res = 0;

    fc_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_req      (ch_req),
        .ch_h        (ch_h),
        .ch_ack      (ch_ack),
        .fc_h        (fc_h),
        .fc_valid    (fc_valid),
        .fc_prob     (fc_prob),
        .fc_done     (fc_done),
        .res_valid   (res_valid),
        .res_ch      (res_ch),
        .res_prob    (res_prob),
        .res_jammed  (res_jammed),
        .res_timeout (res_timeout),
        .switch_req  (switch_req),
        .switch_ch   (switch_ch),
        .jam_status  (jam_status)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void predict(input logic [1:0] ch, input logic [15:0] prob, input bit tmo);
        res_t r;
        logic old_j, new_j;
        old_j = jam_m[ch];
        new_j = old_j;
        if (!tmo) begin
            if (prob > TH_HI) new_j = 1'b1;
            else if (prob < TH_LO) new_j = 1'b0;
        end
        jam_m[ch] = new_j;
        if (!old_j && new_j) sw_ch_m = ch;
        r.ch     = ch;
        r.prob   = tmo ? 16'h0000 : prob;
        r.jammed = new_j;
        r.tmo    = tmo;
        r.sw     = !old_j && new_j;
        r.sw_ch  = sw_ch_m;
        r.jam    = jam_m;
        exp_q.push_back(r);
    endfunction

    task automatic do_reset();
        rst_n   = 1'b0;
        ch_req  = '0;
        fc_done = 1'b0;
        jam_m   = '0;
        sw_ch_m = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(output logic [3:0] ack, output bit ok);
        ok  = 1'b0;
        ack = '0;
        #1;
        for (int i = 0; i < 300; i++) begin
            if (ch_ack != 0) begin
                ack = ch_ack;
                ok  = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_res(output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 300; i++) begin
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            if (ch_ack != 0) stray_acks++;
            tick();
            cyc++;
        end
    endtask

    // Called in the fc_valid cycle; fc_done is presented lat cycles later.
    task automatic engine_reply(input int lat, input logic [15:0] prob, input logic [1:0] ch);
        repeat (lat) begin
            tick();
            if (ch_ack != 0) stray_acks++;
            if (res_valid) stray_res++;
        end
        fc_done = 1'b1;
        fc_prob = prob;
        predict(ch, prob, 1'b0);
        tick();
        fc_done = 1'b0;
        fc_prob = 16'($urandom);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ch_req = 4'b1111;
        #1;
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        ch_req = '0;
        #1;
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL reset_release: got %h want 0", all_out);
        end
    endtask

    task automatic test_single();
        logic [3:0] ack;
        bit ok;
        res_t e;
        ch_req = 4'b0100;
        wait_ack(ack, ok);
        vectors++;
        if (!ok || ack !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_ack: got %b ok=%0d want 0100", ack, ok);
        end
        tick();
        ch_req = '0;
        vectors++;
        if (fc_valid !== 1'b1 || ch_ack !== 4'b0000 || fc_h !== ch_h[2*VEC_W +: VEC_W]) begin
            miscompares++;
            $display("FAIL single_issue: got fc_valid=%b ack=%b fc_h_ok=%0d want 1 0000 1",
                     fc_valid, ch_ack, fc_h === ch_h[2*VEC_W +: VEC_W]);
        end
        engine_reply(20, 16'h0C00, 2'd2);
        e = exp_q.pop_front();
        vectors++;
        if (res_valid !== 1'b1 || act_res !== e) begin
            miscompares++;
            $display("FAIL single_result: got v=%b %h want v=1 %h", res_valid, act_res, e);
        end
        vectors++;
        if ({res_ch, res_prob, res_jammed, switch_req, switch_ch, jam_status} !==
            {2'd2, 16'h0C00, 1'b1, 1'b1, 2'd2, 4'b0100}) begin
            miscompares++;
            $display("FAIL single_switch: got ch=%0d prob=%h j=%b sw=%b swch=%0d jam=%b want 2 0c00 1 1 2 0100",
                     res_ch, res_prob, res_jammed, switch_req, switch_ch, jam_status);
        end
        tick();
        vectors++;
        if (res_valid !== 1'b0 || switch_req !== 1'b0 || res_prob !== 16'h0C00 || switch_ch !== 2'd2) begin
            miscompares++;
            $display("FAIL single_hold: got v=%b sw=%b prob=%h swch=%0d want 0 0 0c00 2",
                     res_valid, switch_req, res_prob, switch_ch);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] ack;
        logic [3:0] exp_ack;
        bit ok;
        res_t e;
        do_reset();
        stray_acks = 0;
        ch_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_ack = 4'(1 << (k % 4));
            wait_ack(ack, ok);
            vectors++;
            if (!ok || ack !== exp_ack || !$onehot(ack)) begin
                miscompares++;
                $display("FAIL rr_grant_%0d: got %b ok=%0d want %b", k, ack, ok, exp_ack);
            end
            tick();
            engine_reply(3 + k, 16'($urandom_range(0, 16'h05FF)), 2'(k % 4));
            e = exp_q.pop_front();
            vectors++;
            if (res_valid !== 1'b1 || act_res !== e) begin
                miscompares++;
                $display("FAIL rr_result_%0d: got v=%b %h want v=1 %h", k, res_valid, act_res, e);
            end
        end
        ch_req = '0;
        vectors++;
        if (stray_acks !== 0) begin
            miscompares++;
            $display("FAIL rr_ack_during_service: got %0d want 0", stray_acks);
        end
    endtask

    task automatic test_hysteresis();
        logic [15:0] probs [4] = '{16'h0B00, 16'h0800, 16'h0500, 16'h0800};
        logic        exp_j [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic        exp_s [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] ack;
        bit ok;
        res_t e;
        for (int i = 0; i < 4; i++) begin
            ch_req = 4'b0010;
            wait_ack(ack, ok);
            vectors++;
            if (!ok || ack !== 4'b0010) begin
                miscompares++;
                $display("FAIL hyst_ack_%0d: got %b ok=%0d want 0010", i, ack, ok);
            end
            tick();
            ch_req = '0;
            engine_reply(5, probs[i], 2'd1);
            e = exp_q.pop_front();
            vectors++;
            if (res_valid !== 1'b1 || act_res !== e || res_jammed !== exp_j[i] || switch_req !== exp_s[i]) begin
                miscompares++;
                $display("FAIL hyst_result_%0d: got v=%b %h j=%b sw=%b want %h j=%b sw=%b",
                         i, res_valid, act_res, res_jammed, switch_req, e, exp_j[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [3:0] ack;
        bit ok;
        int cyc;
        int late;
        res_t e;
        ch_req = 4'b1000;
        wait_ack(ack, ok);
        tick();
        ch_req = '0;
        engine_reply(2, 16'h0F00, 2'd3);
        e = exp_q.pop_front();
        vectors++;
        if (res_valid !== 1'b1 || act_res !== e) begin
            miscompares++;
            $display("FAIL tmo_setup: got v=%b %h want v=1 %h", res_valid, act_res, e);
        end
        ch_req = 4'b1000;
        wait_ack(ack, ok);
        vectors++;
        if (!ok || ack !== 4'b1000) begin
            miscompares++;
            $display("FAIL tmo_ack: got %b ok=%0d want 1000", ack, ok);
        end
        tick();
        ch_req = '0;
        predict(2'd3, 16'h0000, 1'b1);
        wait_res(ok, cyc);
        vectors++;
        if (!ok || cyc !== TIMEOUT + 1) begin
            miscompares++;
            $display("FAIL tmo_latency: got %0d ok=%0d want %0d", cyc, ok, TIMEOUT + 1);
        end
        e = exp_q.pop_front();
        vectors++;
        if (act_res !== e) begin
            miscompares++;
            $display("FAIL tmo_result: got %h want %h", act_res, e);
        end
        tick();
        fc_done = 1'b1;
        fc_prob = 16'h0100;
        late = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            fc_done = 1'b0;
            if (res_valid) late++;
        end
        vectors++;
        if (late !== 0 || jam_status !== jam_m) begin
            miscompares++;
            $display("FAIL tmo_late_done: got res=%0d jam=%b want 0 %b", late, jam_status, jam_m);
        end
    endtask

    task automatic test_terminal_done();
        logic [3:0] ack;
        bit ok;
        res_t e;
        ch_req = 4'b0001;
        wait_ack(ack, ok);
        tick();
        ch_req = '0;
        engine_reply(TIMEOUT, 16'h0700, 2'd0);
        e = exp_q.pop_front();
        vectors++;
        if (res_valid !== 1'b1 || res_timeout !== 1'b0 || act_res !== e) begin
            miscompares++;
            $display("FAIL terminal_done: got v=%b tmo=%b %h want v=1 tmo=0 %h",
                     res_valid, res_timeout, act_res, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] ack;
        bit ok;
        res_t e;
        ch_req = 4'b0101;
        wait_ack(ack, ok);
        vectors++;
        if (!ok || ack !== 4'b0100) begin
            miscompares++;
            $display("FAIL rst_mid_pre_ack: got %b ok=%0d want 0100", ack, ok);
        end
        tick();
        ch_req = 4'b0001;
        repeat (3) tick();
        #2;
        rst_n   = 1'b0;
        jam_m   = '0;
        sw_ch_m = '0;
        exp_q.delete();
        #1;
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got %h want 0", all_out);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        ch_req  = 4'b0101;
        fc_done = 1'b1;
        fc_prob = 16'h0F00;
        wait_ack(ack, ok);
        vectors++;
        if (!ok || ack !== 4'b0001) begin
            miscompares++;
            $display("FAIL rst_mid_regrant: got %b ok=%0d want 0001", ack, ok);
        end
        tick();
        fc_done = 1'b0;
        ch_req  = '0;
        stray_res = 0;
        vectors++;
        if (fc_valid !== 1'b1 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_issue: got fc_valid=%b res_valid=%b want 1 0", fc_valid, res_valid);
        end
        engine_reply(4, 16'h0B00, 2'd0);
        vectors++;
        if (stray_res !== 0) begin
            miscompares++;
            $display("FAIL rst_mid_stale_done: got %0d early results want 0", stray_res);
        end
        e = exp_q.pop_front();
        vectors++;
        if (res_valid !== 1'b1 || act_res !== e) begin
            miscompares++;
            $display("FAIL rst_mid_result: got v=%b %h want v=1 %h", res_valid, act_res, e);
        end
    endtask

    initial begin
        for (int c = 0; c < N_CH; c++) begin
            for (int w = 0; w < VEC_W / 32; w++) begin
                ch_h[c*VEC_W + w*32 +: 32] = $urandom;
            end
        end
        test_reset();
        test_single();
        test_round_robin();
        test_hysteresis();
        test_timeout();
        test_terminal_done();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
